cordic_angle_sequencer: RTL

//  Control and angle-datapath stage upstream of the CORDIC x/y shift-add stage.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_atan_rom.sv | 11 +
 rtl/cordic_angle_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state encoding, pi/2 limit and Q3.29 atan table for the CORDIC angle sequencer
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_t;
  localparam logic [31:0] PIH32 = 32'd843314857;
  localparam logic [31:0] ATAN32 [16] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771757,  32'd8387925,   32'd4194218,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384
  };
  // Round-to-nearest rescale of a Q3.29 constant down to Q3.(w-3)
  function automatic logic [31:0] q29_scale(input logic [31:0] v, input int w);
    int sh;
    sh = 32 - w;
    return sh > 0 ? 32'((64'(v) + (64'd1 << (sh - 1))) >> sh) : v;
  endfunction
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: iteration index to atan(2^-i) in Q3.(WIDTH-3)
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       idx,
  output logic [WIDTH-1:0] atan
);
  always_comb atan = WIDTH'(q29_scale(ATAN32[idx], WIDTH));
endmodule

// File: rtl/cordic_angle_sequencer.sv
// cordic_angle_sequencer: load/iterate control and residual-angle datapath feeding the CORDIC x/y stage
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             done,
  output logic             ld,
  output logic             delta,
  output logic [3:0]       i,
  output logic [WIDTH-1:0] z_res,
  output logic             z_err
);
  localparam logic signed [WIDTH-1:0] PIH = WIDTH'(q29_scale(PIH32, WIDTH));
  localparam logic [3:0] LAST = 4'(ITER - 1);
  state_t state;
  logic [WIDTH-1:0] atan;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] z_next;
  cordic_atan_rom #(.WIDTH(WIDTH)) u_rom (.idx(i), .atan(atan));
  always_comb begin
    delta = state == ROT && !z_res[WIDTH-1];
    sum = delta ? {z_res[WIDTH-1], z_res} - {1'b0, atan} : {z_res[WIDTH-1], z_res} + {1'b0, atan};
    z_next = sum[WIDTH] == sum[WIDTH-1] ? sum[WIDTH-1:0] : {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ld    <= 1'b0;
      i     <= '0;
      z_res <= '0;
      z_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
          ld    <= 1'b1;
          i     <= '0;
          z_res <= Z;
          z_err <= $signed(Z) > PIH || $signed(Z) < -PIH;
        end
        LOAD: begin
          state <= ROT;
          ld    <= 1'b0;
        end
        ROT: begin
          z_res <= z_next;
          if (i == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else i <= i + 4'd1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
